icache_fetch_buffer: RTL and testbench

- Direct-mapped instruction cache between the instruction-fetch unit and the byte-serial memory controller.
- Serves word fetches from IFetch.
- On a miss, issues one word request to the memory controller's icache port and holds it until the response arrives.
- Fills the line and returns the instruction; absorbs pipeline flushes that arrive while a miss is outstanding.

---
 rtl/icache_fetch_buffer_pkg.sv | 14 +
 rtl/icache_fetch_buffer_if.sv | 25 ++
 rtl/icache_fetch_buffer_array.sv | 47 ++++
 rtl/icache_fetch_buffer.sv | 112 +++++++++++
 tb/tb_icache_fetch_buffer.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/icache_fetch_buffer_pkg.sv
// Shared constants and state encoding for the direct-mapped instruction cache.
package icache_fetch_buffer_pkg;

    localparam int ICACHE_INDEX_WIDTH = 6;
    localparam int IC_ADDR_WIDTH      = 32;
    localparam int IC_DATA_WIDTH      = 32;

    typedef enum logic [1:0] {
        IC_IDLE         = 2'd0,
        IC_MISS_WAIT    = 2'd1,
        IC_MISS_DISCARD = 2'd2
    } ic_state_e;

endpackage

// File: rtl/icache_fetch_buffer_if.sv
// IFetch and memory-controller signal bundle; slave is the cache view, master the environment view.
interface icache_fetch_buffer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  if_req_valid;
    logic [ADDR_WIDTH-1:0] if_req_addr;
    logic                  flush;
    logic                  if_resp_valid;
    logic [DATA_WIDTH-1:0] if_resp_inst;
    logic                  mem_req_valid;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic                  mem_resp_valid;
    logic [DATA_WIDTH-1:0] mem_resp_data;

    modport slave (
        input  if_req_valid, if_req_addr, flush, mem_resp_valid, mem_resp_data,
        output if_resp_valid, if_resp_inst, mem_req_valid, mem_req_addr
    );

    modport master (
        output if_req_valid, if_req_addr, flush, mem_resp_valid, mem_resp_data,
        input  if_resp_valid, if_resp_inst, mem_req_valid, mem_req_addr
    );
endinterface

// File: rtl/icache_fetch_buffer_array.sv
// Valid/tag/data line store: combinational read, single write port, 1-cycle clear-all on rst.
// No backpressure; the caller gates wr_en_i with its own stall.
module icache_array
    import icache_fetch_buffer_pkg::*;
#(
    parameter int INDEX_WIDTH = ICACHE_INDEX_WIDTH,
    parameter int TAG_WIDTH   = 24,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INDEX_WIDTH-1:0] rd_idx_i,
    output logic                   rd_valid_o,
    output logic [TAG_WIDTH-1:0]   rd_tag_o,
    output logic [DATA_WIDTH-1:0]  rd_data_o,
    input  logic                   wr_en_i,
    input  logic [INDEX_WIDTH-1:0] wr_idx_i,
    input  logic [TAG_WIDTH-1:0]   wr_tag_i,
    input  logic [DATA_WIDTH-1:0]  wr_data_i
);
    localparam int LINES = 1 << INDEX_WIDTH;

    logic [LINES-1:0]      valid_q;
    logic [TAG_WIDTH-1:0]  tag_q  [LINES];
    logic [DATA_WIDTH-1:0] data_q [LINES];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    // Tag and data need no reset: they are only ever read qualified by valid.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/icache_fetch_buffer.sv
// Direct-mapped one-word-line icache: hit returns next cycle, a miss holds one level request
// until the memory word arrives; rdy low freezes everything, flush mid-miss drops the reply.
module icache_fetch_buffer
    import icache_fetch_buffer_pkg::*;
#(
    parameter int INDEX_WIDTH = ICACHE_INDEX_WIDTH,
    parameter int ADDR_WIDTH  = IC_ADDR_WIDTH,
    parameter int DATA_WIDTH  = IC_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    icache_fetch_buffer_if.slave  bus
);
    localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - 2;

    ic_state_e              state_q;
    logic                   if_resp_valid_q;
    logic [DATA_WIDTH-1:0]  if_resp_inst_q;
    logic                   mem_req_valid_q;
    logic [ADDR_WIDTH-1:0]  mem_req_addr_q;
    logic [INDEX_WIDTH-1:0] miss_idx_q;
    logic [TAG_WIDTH-1:0]   miss_tag_q;

    logic [INDEX_WIDTH-1:0] req_idx;
    logic [TAG_WIDTH-1:0]   req_tag;
    logic                   rd_valid;
    logic [TAG_WIDTH-1:0]   rd_tag;
    logic [DATA_WIDTH-1:0]  rd_data;
    logic                   hit;
    logic                   fill_en;
    logic                   unused_addr_bits;

    assign req_idx          = bus.if_req_addr[INDEX_WIDTH+1:2];
    assign req_tag          = bus.if_req_addr[ADDR_WIDTH-1:INDEX_WIDTH+2];
    assign unused_addr_bits = ^bus.if_req_addr[1:0];
    assign hit              = rd_valid && (rd_tag == req_tag);
    // Both miss states fill on the response: even a discarded word is correct for its line.
    assign fill_en          = rdy && (state_q != IC_IDLE) && bus.mem_resp_valid;

    icache_array #(
        .INDEX_WIDTH (INDEX_WIDTH),
        .TAG_WIDTH   (TAG_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .rd_idx_i   (req_idx),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data),
        .wr_en_i    (fill_en),
        .wr_idx_i   (miss_idx_q),
        .wr_tag_i   (miss_tag_q),
        .wr_data_i  (bus.mem_resp_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IC_IDLE;
            if_resp_valid_q <= 1'b0;
            if_resp_inst_q  <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
            miss_idx_q      <= '0;
            miss_tag_q      <= '0;
        end else if (rdy) begin
            if_resp_valid_q <= 1'b0;
            case (state_q)
                IC_IDLE: begin
                    if (bus.if_req_valid && !bus.flush) begin
                        if (hit) begin
                            if_resp_valid_q <= 1'b1;
                            if_resp_inst_q  <= rd_data;
                        end else begin
                            mem_req_valid_q <= 1'b1;
                            mem_req_addr_q  <= {bus.if_req_addr[ADDR_WIDTH-1:2], 2'b00};
                            miss_idx_q      <= req_idx;
                            miss_tag_q      <= req_tag;
                            state_q         <= IC_MISS_WAIT;
                        end
                    end
                end
                IC_MISS_WAIT: begin
                    if (bus.mem_resp_valid) begin
                        mem_req_valid_q <= 1'b0;
                        state_q         <= IC_IDLE;
                        if (!bus.flush) begin
                            if_resp_valid_q <= 1'b1;
                            if_resp_inst_q  <= bus.mem_resp_data;
                        end
                    end else if (bus.flush) begin
                        state_q <= IC_MISS_DISCARD;
                    end
                end
                IC_MISS_DISCARD: begin
                    if (bus.mem_resp_valid) begin
                        mem_req_valid_q <= 1'b0;
                        state_q         <= IC_IDLE;
                    end
                end
                default: state_q <= IC_IDLE;
            endcase
        end
    end

    assign bus.if_resp_valid = if_resp_valid_q;
    assign bus.if_resp_inst  = if_resp_inst_q;
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_req_addr  = mem_req_addr_q;

endmodule

// File: tb/tb_icache_fetch_buffer.sv
// Directed bench for icache_fetch_buffer with a response scoreboard.
module tb_icache_fetch_buffer;
    logic clk = 1'b0;
    logic rst;
    logic rdy;
    int   vectors    = 0;
    int   miscompares = 0;
    logic [31:0] exp_q[$];

    icache_fetch_buffer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    icache_fetch_buffer dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every response pulse must match the oldest expected instruction.
    always @(negedge clk) begin
        if (bus.if_resp_valid !== 1'b0) begin
            if (exp_q.size() == 0) check("spurious_resp", {63'd0, bus.if_resp_valid}, 64'd0);
            else                   check("resp_inst", {32'd0, bus.if_resp_inst}, {32'd0, exp_q.pop_front()});
        end
    end

    task automatic miss_fill(input logic [31:0] addr, input logic [31:0] data, input int delay);
        bus.if_req_valid = 1'b1;
        bus.if_req_addr  = addr;
        exp_q.push_back(data);
        tick();
        check("miss_req_valid", {63'd0, bus.mem_req_valid}, 64'd1);
        check("miss_req_addr", {32'd0, bus.mem_req_addr}, {32'd0, addr & 32'hFFFF_FFFC});
        repeat (delay - 1) tick();
        check("miss_req_held", {63'd0, bus.mem_req_valid}, 64'd1);
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = data;
        tick();
        bus.mem_resp_valid = 1'b0;
        bus.if_req_valid   = 1'b0;
        check("fill_req_drop", {63'd0, bus.mem_req_valid}, 64'd0);
        check("fill_pulse", {63'd0, bus.if_resp_valid}, 64'd1);
        tick();
        check("fill_pulse_single", {63'd0, bus.if_resp_valid}, 64'd0);
    endtask

    task automatic hit(input logic [31:0] addr, input logic [31:0] data);
        bus.if_req_valid = 1'b1;
        bus.if_req_addr  = addr;
        exp_q.push_back(data);
        tick();
        bus.if_req_valid = 1'b0;
        check("hit_pulse", {63'd0, bus.if_resp_valid}, 64'd1);
        check("hit_no_mem_req", {63'd0, bus.mem_req_valid}, 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        bus.if_req_valid   = 1'b0;
        bus.if_req_addr    = '0;
        bus.flush          = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_resp_valid", {63'd0, bus.if_resp_valid}, 64'd0);
        check("rst_resp_inst", {32'd0, bus.if_resp_inst}, 64'd0);
        check("rst_mem_req", {63'd0, bus.mem_req_valid}, 64'd0);
        check("rst_mem_addr", {32'd0, bus.mem_req_addr}, 64'd0);

        // Cold miss, then hits including back-to-back
        miss_fill(32'h0000_0000, 32'h0000_0013, 5);
        hit(32'h0000_0000, 32'h0000_0013);
        miss_fill(32'h0000_0004, 32'h4000_0093, 2);
        bus.if_req_valid = 1'b1;
        bus.if_req_addr  = 32'h0000_0000;
        exp_q.push_back(32'h0000_0013);
        tick();
        check("b2b_first", {32'd0, bus.if_resp_inst}, 64'h13);
        bus.if_req_addr  = 32'h0000_0006;
        exp_q.push_back(32'h4000_0093);
        tick();
        bus.if_req_valid = 1'b0;
        check("b2b_second_valid", {63'd0, bus.if_resp_valid}, 64'd1);
        check("b2b_second", {32'd0, bus.if_resp_inst}, 64'h4000_0093);

        // Conflict on index 0 evicts line 0x0
        miss_fill(32'h0000_0100, 32'h1111_1111, 3);
        miss_fill(32'h0000_0000, 32'h0000_0013, 3);

        // Flush two cycles into a miss: reply is dropped but still fills
        bus.if_req_valid = 1'b1;
        bus.if_req_addr  = 32'h0000_0040;
        tick();
        check("flushmiss_req", {32'd0, bus.mem_req_addr}, 64'h40);
        tick();
        bus.flush        = 1'b1;
        bus.if_req_valid = 1'b0;
        tick();
        bus.flush = 1'b0;
        check("discard_req_held", {63'd0, bus.mem_req_valid}, 64'd1);
        tick();
        tick();
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 32'hDEAD_BEEF;
        tick();
        bus.mem_resp_valid = 1'b0;
        check("discard_no_pulse", {63'd0, bus.if_resp_valid}, 64'd0);
        check("discard_req_drop", {63'd0, bus.mem_req_valid}, 64'd0);
        hit(32'h0000_0040, 32'hDEAD_BEEF);

        // Flush on the same edge as the response
        bus.if_req_valid = 1'b1;
        bus.if_req_addr  = 32'h0000_0080;
        tick();
        tick();
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 32'hCAFE_F00D;
        bus.flush          = 1'b1;
        bus.if_req_valid   = 1'b0;
        tick();
        bus.mem_resp_valid = 1'b0;
        bus.flush          = 1'b0;
        check("coinc_no_pulse", {63'd0, bus.if_resp_valid}, 64'd0);
        check("coinc_req_drop", {63'd0, bus.mem_req_valid}, 64'd0);
        tick();
        check("coinc_req_low", {63'd0, bus.mem_req_valid}, 64'd0);
        hit(32'h0000_0080, 32'hCAFE_F00D);

        // Flush in IDLE blocks a lookup
        bus.if_req_valid = 1'b1;
        bus.if_req_addr  = 32'h0000_0000;
        bus.flush        = 1'b1;
        tick();
        bus.if_req_valid = 1'b0;
        bus.flush        = 1'b0;
        check("idleflush_no_pulse", {63'd0, bus.if_resp_valid}, 64'd0);
        check("idleflush_no_req", {63'd0, bus.mem_req_valid}, 64'd0);

        // rdy low for three cycles during MISS_WAIT
        bus.if_req_valid = 1'b1;
        bus.if_req_addr  = 32'h0000_00C0;
        tick();
        rdy = 1'b0;
        bus.if_req_addr = 32'h0000_0200;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("frz_req_valid", {63'd0, bus.mem_req_valid}, 64'd1);
            check("frz_req_addr", {32'd0, bus.mem_req_addr}, 64'hC0);
            check("frz_no_pulse", {63'd0, bus.if_resp_valid}, 64'd0);
        end
        rdy = 1'b1;
        bus.if_req_addr    = 32'h0000_00C0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 32'h0BAD_C0DE;
        exp_q.push_back(32'h0BAD_C0DE);
        tick();
        bus.mem_resp_valid = 1'b0;
        bus.if_req_valid   = 1'b0;
        check("frz_resume_pulse", {63'd0, bus.if_resp_valid}, 64'd1);
        check("frz_resume_drop", {63'd0, bus.mem_req_valid}, 64'd0);
        tick();

        // Reset mid-miss, then a previously filled line misses
        bus.if_req_valid = 1'b1;
        bus.if_req_addr  = 32'h0000_0300;
        tick();
        check("rstmiss_req", {32'd0, bus.mem_req_addr}, 64'h300);
        rst = 1'b1;
        bus.if_req_valid = 1'b0;
        tick();
        rst = 1'b0;
        check("rst2_resp_valid", {63'd0, bus.if_resp_valid}, 64'd0);
        check("rst2_resp_inst", {32'd0, bus.if_resp_inst}, 64'd0);
        check("rst2_mem_req", {63'd0, bus.mem_req_valid}, 64'd0);
        check("rst2_mem_addr", {32'd0, bus.mem_req_addr}, 64'd0);
        miss_fill(32'h0000_0004, 32'h4000_0093, 2);

        tick();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
